// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: instruction field widths, the control word
// produced by the control ROM, and the entry format held between IF and ID.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_AND  = 3'd1,
    ALU_NOT  = 3'd2,
    ALU_PASS = 3'd3,
    ALU_SLL  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_SRA  = 3'd6,
    ALU_RSVD = 3'd7
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode  opcode;
    lc3b_aluop   aluop;
    logic        load_regfile;
    logic        load_cc;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  pcmux_sel;
  } lc3b_control_word;

  // One fetched instruction as it sits in the IF/ID buffer.
  typedef struct packed {
    lc3b_word         pc;
    lc3b_word         instr;
    lc3b_control_word ctrl;
  } lc3b_fetch_entry;

  function automatic lc3b_word sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic lc3b_word sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

endpackage

// File: rtl/lc3b_ir_fields.sv
// Purely combinational split of an LC-3b instruction word into its fields.
// Offsets are raw bit slices; the two immediates are sign-extended to a word.
module lc3b_ir_fields
  import lc3b_types::*;
(
  input  lc3b_word     instr_i,
  output lc3b_opcode   opcode_o,
  output lc3b_reg      dest_o,
  output lc3b_reg      src1_o,
  output lc3b_reg      src2_o,
  output lc3b_offset6  offset6_o,
  output lc3b_offset9  offset9_o,
  output lc3b_offset11 offset11_o,
  output lc3b_word     imm5_o,
  output lc3b_word     imm4_o
);

  assign opcode_o   = instr_i[15:12];
  assign dest_o     = instr_i[11:9];
  assign src1_o     = instr_i[8:6];
  assign src2_o     = instr_i[2:0];
  assign offset6_o  = instr_i[5:0];
  assign offset9_o  = instr_i[8:0];
  assign offset11_o = instr_i[10:0];
  assign imm5_o     = sext5(instr_i[4:0]);
  assign imm4_o     = sext4(instr_i[3:0]);

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: a DEPTH-entry circular FIFO of fetched
// {pc, instr, ctrl}. The head slot drives the outputs combinationally and is
// decoded in place so the ID stage sees the fields without an extra cycle.
module if_id_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  lc3b_word         in_pc,
  input  lc3b_word         in_instr,
  input  lc3b_control_word in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output lc3b_word         out_pc,
  output lc3b_word         out_instr,
  output lc3b_control_word out_ctrl,
  output lc3b_opcode       opcode,
  output lc3b_reg          dest,
  output lc3b_reg          src1,
  output lc3b_reg          src2,
  output lc3b_offset6      offset6,
  output lc3b_offset9      offset9,
  output lc3b_offset11     offset11,
  output lc3b_word         imm5,
  output lc3b_word         imm4,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lc3b_fetch_entry  mem_q [DEPTH];
  lc3b_fetch_entry  head_entry;
  lc3b_fetch_entry  in_entry;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  assign in_entry   = '{pc: in_pc, instr: in_instr, ctrl: in_ctrl};
  assign head_entry = mem_q[head_q];
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;
  assign out_ctrl   = head_entry.ctrl;

  // Next pointers and occupancy; flush overrides any concurrent push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: cleared on reset so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[tail_q] <= in_entry;
    end
  end

  lc3b_ir_fields u_fields (
    .instr_i    (head_entry.instr),
    .opcode_o   (opcode),
    .dest_o     (dest),
    .src1_o     (src1),
    .src2_o     (src2),
    .offset6_o  (offset6),
    .offset9_o  (offset9),
    .offset11_o (offset11),
    .imm5_o     (imm5),
    .imm4_o     (imm4)
  );

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: two instances (DEPTH=2 and DEPTH=3) share one
// stimulus stream; each has its own queue-based reference and scoreboard.
module tb_if_id_buffer;
  import lc3b_types::*;

  typedef struct {
    lc3b_word         pc;
    lc3b_word         instr;
    lc3b_control_word ctrl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, in_valid, out_ready;
  lc3b_word         in_pc, in_instr;
  lc3b_control_word in_ctrl;

  logic             in_ready2, out_valid2;
  lc3b_word         out_pc2, out_instr2, imm5_2, imm4_2;
  lc3b_control_word out_ctrl2;
  lc3b_opcode       opcode2;
  lc3b_reg          dest2, src1_2, src2_2;
  lc3b_offset6      off6_2;
  lc3b_offset9      off9_2;
  lc3b_offset11     off11_2;
  logic [1:0]       count2;

  logic             in_ready3, out_valid3;
  lc3b_word         out_pc3, out_instr3, imm5_3, imm4_3;
  lc3b_control_word out_ctrl3;
  lc3b_opcode       opcode3;
  lc3b_reg          dest3, src1_3, src2_3;
  lc3b_offset6      off6_3;
  lc3b_offset9      off9_3;
  lc3b_offset11     off11_3;
  logic [1:0]       count3;

  if_id_buffer #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_instr(out_instr2), .out_ctrl(out_ctrl2),
    .opcode(opcode2), .dest(dest2), .src1(src1_2), .src2(src2_2),
    .offset6(off6_2), .offset9(off9_2), .offset11(off11_2),
    .imm5(imm5_2), .imm4(imm4_2), .count(count2)
  );

  if_id_buffer #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_pc(out_pc3), .out_instr(out_instr3), .out_ctrl(out_ctrl3),
    .opcode(opcode3), .dest(dest3), .src1(src1_3), .src2(src2_3),
    .offset6(off6_3), .offset9(off9_3), .offset11(off11_3),
    .imm5(imm5_3), .imm4(imm4_3), .count(count3)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q2[$];
  exp_t q3[$];
  int   occ2 = 0;
  int   occ3 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fld(input int v, input int lo, input int n);
    return (v >> lo) % (1 << n);
  endfunction

  function automatic int sx(input int v, input int n);
    int r;
    r = v;
    if (r >= (1 << (n - 1))) r = r - (1 << n);
    return r & 16'hFFFF;
  endfunction

  task automatic cmp_head(input string tag, input exp_t e,
                          input lc3b_word pc, input lc3b_word ins, input lc3b_control_word ctl,
                          input lc3b_opcode opc, input lc3b_reg dst, input lc3b_reg s1,
                          input lc3b_reg s2, input lc3b_offset6 o6, input lc3b_offset9 o9,
                          input lc3b_offset11 o11, input lc3b_word i5, input lc3b_word i4);
    int v;
    v = int'(e.instr);
    chk({tag, "_pc"},    32'(pc),  32'(e.pc));
    chk({tag, "_instr"}, 32'(ins), 32'(e.instr));
    chk({tag, "_ctrl"},  32'(ctl), 32'(e.ctrl));
    chk({tag, "_opc"},   32'(opc), fld(v, 12, 4));
    chk({tag, "_dest"},  32'(dst), fld(v, 9, 3));
    chk({tag, "_src1"},  32'(s1),  fld(v, 6, 3));
    chk({tag, "_src2"},  32'(s2),  fld(v, 0, 3));
    chk({tag, "_off6"},  32'(o6),  fld(v, 0, 6));
    chk({tag, "_off9"},  32'(o9),  fld(v, 0, 9));
    chk({tag, "_off11"}, 32'(o11), fld(v, 0, 11));
    chk({tag, "_imm5"},  32'(i5),  sx(fld(v, 0, 5), 5));
    chk({tag, "_imm4"},  32'(i4),  sx(fld(v, 0, 4), 4));
  endtask

  // Stimulus side of the scoreboard: record accepted entries at each edge.
  always @(posedge clk) begin
    exp_t e;
    bit   a, p;
    if (rst_n === 1'b1) begin
      if (flush) begin
        q2.delete(); occ2 = 0;
        q3.delete(); occ3 = 0;
      end else begin
        e.pc = in_pc; e.instr = in_instr; e.ctrl = in_ctrl;
        p = (occ2 != 0) && out_ready;
        a = in_valid && (occ2 < 2);
        if (a) q2.push_back(e);
        occ2 = occ2 + int'(a) - int'(p);
        p = (occ3 != 0) && out_ready;
        a = in_valid && (occ3 < 3);
        if (a) q3.push_back(e);
        occ3 = occ3 + int'(a) - int'(p);
      end
    end
  end

  always @(negedge rst_n) begin
    q2.delete(); occ2 = 0;
    q3.delete(); occ3 = 0;
  end

  // Monitor: status every cycle, head contents whenever the buffer is valid.
  always @(negedge clk) begin
    chk("cnt2",  32'(count2),     occ2);
    chk("vld2",  32'(out_valid2), 32'(occ2 != 0));
    chk("rdy2",  32'(in_ready2),  32'(occ2 < 2));
    chk("cnt3",  32'(count3),     occ3);
    chk("vld3",  32'(out_valid3), 32'(occ3 != 0));
    chk("rdy3",  32'(in_ready3),  32'(occ3 < 3));
    if (occ2 != 0 && q2.size() != 0) begin
      cmp_head("h2", q2[0], out_pc2, out_instr2, out_ctrl2, opcode2, dest2, src1_2, src2_2,
               off6_2, off9_2, off11_2, imm5_2, imm4_2);
      if (out_ready && !flush && rst_n) void'(q2.pop_front());
    end
    if (occ3 != 0 && q3.size() != 0) begin
      cmp_head("h3", q3[0], out_pc3, out_instr3, out_ctrl3, opcode3, dest3, src1_3, src2_3,
               off6_3, off9_3, off11_3, imm5_3, imm4_3);
      if (out_ready && !flush && rst_n) void'(q3.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic offer(input lc3b_word pc, input lc3b_word ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    in_ctrl  = lc3b_control_word'($urandom_range(0, 8191));
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_ctrl = '0;
    #1 rst_n = 1'b0;
    step(); step();
    look();
    chk("rst_pc2",    32'(out_pc2),    0);
    chk("rst_instr2", 32'(out_instr2), 0);
    chk("rst_ctrl2",  32'(out_ctrl2),  0);
    chk("rst_opc2",   32'(opcode2),    0);
    chk("rst_imm5_2", 32'(imm5_2),     0);
    chk("rst_off11_3", 32'(off11_3),   0);
    chk("rst_rdy3",   32'(in_ready3),  1);
    step(); rst_n = 1'b1;
    step(); step();
    look();
    chk("idle_vld2", 32'(out_valid2), 0);
    chk("idle_rdy2", 32'(in_ready2),  1);
    chk("idle_cnt2", 32'(count2),     0);

    // Fill DEPTH=2 with two entries, then pop them one at a time.
    step(); offer(16'h0010, 16'h1042);
    step(); offer(16'h0012, 16'h5A7F);
    step(); in_valid = 1'b0;
    look();
    chk("full_cnt2", 32'(count2),    2);
    chk("full_rdy2", 32'(in_ready2), 0);
    chk("full_rdy3", 32'(in_ready3), 1);
    step(); out_ready = 1'b1;
    look();
    chk("pop1_pc",   32'(out_pc2), 32'h0010);
    chk("pop1_opc",  32'(opcode2), 1);
    chk("pop1_dest", 32'(dest2),   0);
    chk("pop1_src1", 32'(src1_2),  1);
    chk("pop1_src2", 32'(src2_2),  2);
    chk("pop1_imm5", 32'(imm5_2),  32'h0002);
    step();
    look();
    chk("pop2_pc",   32'(out_pc2), 32'h0012);
    chk("pop2_imm5", 32'(imm5_2),  32'hFFFF);
    step(); out_ready = 1'b0;
    look();
    chk("drain_cnt2", 32'(count2), 0);

    // Offset slices and imm4 sign extension.
    offer(16'h0040, 16'h0E08);
    step(); in_valid = 1'b0;
    look();
    chk("f_off9",  32'(off9_2),  32'h008);
    chk("f_off11", 32'(off11_2), 32'h608);
    chk("f_imm4",  32'(imm4_2),  32'hFFF8);
    chk("f_imm5",  32'(imm5_2),  32'h0008);
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;

    // Fill completely, then flush while a new entry is offered.
    for (int i = 0; i < 3; i++) begin
      offer(16'h0100 + 16'(2 * i), 16'($urandom));
      step();
    end
    flush = 1'b1; offer(16'h0BAD, 16'h1234);
    step(); flush = 1'b0; in_valid = 1'b0;
    look();
    chk("fl_cnt2", 32'(count2),     0);
    chk("fl_vld2", 32'(out_valid2), 0);
    chk("fl_rdy2", 32'(in_ready2),  1);
    chk("fl_cnt3", 32'(count3),     0);

    // Steady push+pop at DEPTH=3 across several pointer wraps.
    offer(16'h0200, 16'($urandom)); step();
    offer(16'h0202, 16'($urandom)); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(16'h0300 + 16'(2 * i), 16'($urandom));
      step();
      look();
      chk("steady_cnt3", 32'(count3), 2);
    end
    in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle with two entries held.
    offer(16'h0400, 16'($urandom)); step();
    offer(16'h0402, 16'($urandom)); step();
    offer(16'h0404, 16'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld2", 32'(out_valid2), 0);
    chk("arst_vld3", 32'(out_valid3), 0);
    chk("arst_cnt3", 32'(count3),     0);
    step(); in_valid = 1'b0; rst_n = 1'b1;
    step();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = 16'($urandom);
      in_instr  = 16'($urandom);
      in_ctrl   = lc3b_control_word'($urandom_range(0, 8191));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    look();
    chk("end_cnt2", 32'(count2), 0);
    chk("end_cnt3", 32'(count3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered fetch entries; legal range 1..8.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  synchronous discard of all entries (branch/mispredict).
REQ-006 in_valid  in  1  fetch stage offers an entry.
REQ-007 in_ready  out  1  buffer accepts an entry this cycle.
REQ-008 in_pc  in  lc3b_word  PC of offered instruction.
REQ-009 in_instr  in  lc3b_word  instruction word.
REQ-010 in_ctrl  in  lc3b_control_word  control word from control ROM.
REQ-011 out_valid  out  1  head entry is valid.
REQ-012 out_ready  in  1  decode stage consumes head.
REQ-013 out_pc, out_instr  out  lc3b_word  head PC and instruction.
REQ-014 out_ctrl  out  lc3b_control_word  head control word.
REQ-015 opcode  out  lc3b_opcode  out_instr[15:12].
REQ-016 dest, src1, src2  out  lc3b_reg  out_instr[11:9], [8:6], [2:0].
REQ-017 offset6, offset9, offset11  out  lc3b_offset6/9/11  out_instr[5:0], [8:0], [10:0], raw.
REQ-018 imm5, imm4  out  lc3b_word  sign-extended out_instr[4:0], [3:0].
REQ-019 count  out  CNT_W  current occupancy 0..DEPTH.

Function
REQ-020 Storage is a circular buffer of DEPTH entries {pc, instr, ctrl} with head and tail pointers.
REQ-021 in_ready SHALL equal (count < DEPTH); no same-cycle bypass when full.
REQ-022 Push occurs when in_valid && in_ready && !flush; entry written at tail, tail advances.
REQ-023 Pop occurs when out_valid && out_ready && !flush; head advances.
REQ-024 out_valid SHALL equal (count != 0).
REQ-025 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-026 Latency: entry pushed at edge N is visible on out_* with out_valid=1 after edge N (one cycle), even if the buffer was empty.
REQ-027 Pointers wrap from DEPTH-1 to 0; SHALL be correct for non-power-of-2 DEPTH.
REQ-028 out_pc/out_instr/out_ctrl and all decoded fields SHALL reflect the head slot combinationally; decoded fields derive only from out_instr.
REQ-029 flush=1 at edge: count, head, tail return to 0; concurrent push and pop are discarded; in_ready=1 next cycle.
REQ-030 While out_valid=0, data outputs SHALL hold the value of the head slot and are not to be interpreted; the bench SHALL not check them.
REQ-031 Entries SHALL not change while resident; out_* stable while out_valid && !out_ready.
REQ-032 in_valid with in_ready=0 SHALL not alter state; the offering stage holds its inputs.

Reset
REQ-033 rst_n low SHALL immediately clear count, head, and tail, and zero all storage slots.
REQ-034 After reset: out_valid=0, in_ready=1, count=0, out_pc/out_instr=16'h0000, out_ctrl all-zero, decoded fields zero.
REQ-035 Reset assertion mid-operation SHALL discard all entries, including any push in progress.

Structure
REQ-036 lc3b_word, lc3b_opcode, lc3b_reg, lc3b_offset6/9/11 and lc3b_control_word SHALL come from package lc3b_types; no local redefinition.
REQ-037 Field extraction SHALL be one combinational sub-module, lc3b_ir_fields (instr in, decoded fields out), reusable by other stages.

Verification
REQ-038 Reset, then idle -> out_valid=0, in_ready=1, count=0.
REQ-039 DEPTH=2: push pc 16'h0010/instr 16'h1042, 16'h0012/16'h5A7F with out_ready=0 -> count=2, in_ready=0. Then pop -> head pc 16'h0010, opcode 4'h1, dest 0, src1 1, src2 2, imm5 16'h0002. Next pop -> imm5 16'hFFFF.
REQ-040 Continuous push+pop for 10 cycles at DEPTH=3 -> count constant, FIFO order preserved across pointer wrap.
REQ-041 Full buffer, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, flushed push absent.
REQ-042 rst_n low asynchronously mid-cycle with count=2 -> out_valid=0 before next clk edge.
REQ-043 Push instr 16'h0E08 -> offset9 9'h008, offset11 11'h608, imm4 16'h0008 → 16'hFFF8 sign check.
